uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 158 +++++++++++++++
 tb/tb_uart_tx_framer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start, LSB-first data, optional even parity, stop.
// Define UART_TX_PARITY_EN to include the PARITY state and parity bit.
module uart_tx_framer #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CLOCKS_PER_BIT   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INPUT_DATA_WIDTH-1:0] data_in,
  input  logic                        data_in_valid,
  output logic                        tx_ready,
  output logic                        serial_out,
  output logic                        tx_busy
);

  localparam int BW = $clog2(CLOCKS_PER_BIT);
  localparam int IW = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(INPUT_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                      state_q, state_d;
  logic [BW-1:0]               baud_q, baud_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [INPUT_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                        serial_q, serial_d;
  logic                        ready_q, ready_d;
  logic                        baud_last;
`ifdef UART_TX_PARITY_EN
  logic                        parity_q, parity_d;
`endif

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    ready_d  = ready_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (data_in_valid && ready_q) begin
          state_d  = START;
          shift_d  = data_in;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data_in;
`endif
          serial_d = 1'b0;
          ready_d  = 1'b0;
          baud_d   = '0;
          idx_d    = '0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d  = DATA;
          baud_d   = '0;
          serial_d = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
            serial_d = parity_q;
`else
            state_d  = STOP;
            serial_d = 1'b1;
`endif
          end else begin
            // The shift register keeps the next data bit in position 0.
            idx_d    = idx_q + 1'b1;
            shift_d  = shift_q >> 1;
            serial_d = shift_d[0];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          state_d  = STOP;
          baud_d   = '0;
          serial_d = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          state_d  = IDLE;
          baud_d   = '0;
          serial_d = 1'b1;
          ready_d  = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        baud_d   = '0;
        idx_d    = '0;
        serial_d = 1'b1;
        ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign serial_out = serial_q;
  assign tx_ready   = ready_q;
  assign tx_busy    = ~ready_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - self-checking bench for uart_tx_framer against a frame-level model.
module tb_uart_tx_framer;

  localparam int CPB = 4;
  localparam int W   = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB  = W + 3;
`else
  localparam int NB  = W + 2;
`endif
  localparam int FRAME = NB * CPB;
  localparam int PER   = FRAME + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_in_valid = 1'b0;
  logic         tx_ready, serial_out, tx_busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic cap_line [0:255];
  logic cap_rdy  [0:255];

  uart_tx_framer #(.INPUT_DATA_WIDTH(W), .CLOCKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
    .tx_ready(tx_ready), .serial_out(serial_out), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Line level k cycles after the transfer edge, from the frame rules.
  function automatic logic exp_line(input logic [W-1:0] d, input int k);
    int b;
    b = k / CPB;
    if (k < 0 || b >= NB) return 1'b1;
    if (b == 0) return 1'b0;
    if (b <= W) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == W + 1) return logic'($countones(d) % 2);
`endif
    return 1'b1;
  endfunction

  // Caller is at a negedge; records n samples after the transfer edge.
  task automatic send_capture(input logic [W-1:0] d, input int n, input int pulse_at,
                              input logic [W-1:0] pd);
    data_in = d;
    data_in_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cap_line[k] = serial_out;
      cap_rdy[k]  = tx_ready;
      data_in = W'($urandom);
      data_in_valid = (k == pulse_at);
      if (k == pulse_at) data_in = pd;
    end
    data_in_valid = 1'b0;
  endtask

  task automatic check_capture(input string name, input logic [W-1:0] d, input int n);
    int bad_line, bad_rdy;
    bad_line = 0;
    bad_rdy = 0;
    for (int k = 0; k < n; k++) begin
      if (cap_line[k] !== exp_line(d, k)) bad_line++;
      if (cap_rdy[k] !== (k >= FRAME)) bad_rdy++;
    end
    tests_run++;
    if (bad_line != 0) begin
      tests_failed++;
      $display("FAIL %s line: %0d cycles wrong (data %h), required 0", name, bad_line, d);
    end
    tests_run++;
    if (bad_rdy != 0) begin
      tests_failed++;
      $display("FAIL %s tx_ready: %0d cycles wrong (data %h), required 0", name, bad_rdy, d);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    tests_run++;
    if (serial_out !== 1'b1) begin tests_failed++; $display("FAIL reset serial_out: got %b need 1", serial_out); end
    tests_run++;
    if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset tx_ready: got %b need 1", tx_ready); end
    tests_run++;
    if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset tx_busy: got %b need 0", tx_busy); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_a5;
    int lows;
    send_capture(8'hA5, PER + 4, -1, '0);
    check_capture("a5", 8'hA5, PER + 4);
    lows = 0;
    for (int k = 0; k < PER + 4; k++) if (cap_rdy[k] === 1'b0) lows++;
    tests_run++;
    if (lows != FRAME) begin
      tests_failed++;
      $display("FAIL a5 ready_low_cycles: got %0d need %0d", lows, FRAME);
    end
  endtask

  task automatic test_parity;
    logic [W-1:0] d;
    for (int t = 0; t < 2; t++) begin
      d = (t == 0) ? 8'h01 : 8'h00;
      send_capture(d, PER, -1, '0);
`ifdef UART_TX_PARITY_EN
      tests_run++;
      if (cap_line[(W + 1) * CPB + 1] !== ((t == 0) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL parity_bit data %h: got %b need %b", d, cap_line[(W + 1) * CPB + 1], (t == 0));
      end
`endif
      tests_run++;
      if (cap_line[(NB - 1) * CPB + 2] !== 1'b1) begin
        tests_failed++;
        $display("FAIL stop_bit data %h: got %b need 1", d, cap_line[(NB - 1) * CPB + 2]);
      end
      check_capture("parity_frame", d, PER);
    end
  endtask

  task automatic test_back_to_back;
    int bad, second;
    data_in = 8'hFF;
    data_in_valid = 1'b1;
    @(posedge clk);
    bad = 0;
    second = -1;
    for (int k = 0; k < 2 * PER + 4; k++) begin
      @(negedge clk);
      cap_line[k] = serial_out;
      if (k < PER) begin
        if (serial_out !== exp_line(8'hFF, k)) bad++;
      end else begin
        if (serial_out !== exp_line(8'h00, k - PER)) bad++;
      end
      if (k >= FRAME && second < 0 && serial_out === 1'b0) second = k;
      data_in = 8'h00;
      if (k >= PER) data_in_valid = 1'b0;
    end
    data_in_valid = 1'b0;
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL b2b line: %0d cycles wrong, required 0", bad); end
    tests_run++;
    if (cap_line[FRAME] !== 1'b1) begin tests_failed++; $display("FAIL b2b idle_gap: got %b need 1", cap_line[FRAME]); end
    tests_run++;
    if (second != PER) begin tests_failed++; $display("FAIL b2b start_spacing: got %0d need %0d", second, PER); end
  endtask

  task automatic test_ignore;
    logic [W-1:0] d;
    d = W'($urandom);
    send_capture(d, PER + 3 * CPB, 6 * CPB + 1, 8'h3C);
    check_capture("ignore_pulse", d, PER + 3 * CPB);
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] d;
    d = W'($urandom) & 8'hF7;
    data_in = d;
    data_in_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4 * CPB + 2; k++) begin
      @(negedge clk);
      data_in_valid = 1'b0;
    end
    tests_run++;
    if (serial_out !== 1'b0) begin tests_failed++; $display("FAIL midreset pre_bit3: got %b need 0", serial_out); end
    reset = 1'b0;
    #1;
    tests_run++;
    if (serial_out !== 1'b1) begin tests_failed++; $display("FAIL midreset async_high: got %b need 1", serial_out); end
    tests_run++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset flags: ready %b busy %b need 1 0", tx_ready, tx_busy);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (serial_out !== 1'b1) begin tests_failed++; $display("FAIL midreset no_resume: got %b need 1", serial_out); end
    send_capture(8'h5A, PER + 2, -1, '0);
    check_capture("after_reset_5a", 8'h5A, PER + 2);
  endtask

  task automatic test_random;
    logic [W-1:0] d;
    for (int i = 0; i < 6; i++) begin
      d = W'($urandom);
      send_capture(d, PER + 1 + (i % 3), -1, '0);
      check_capture("random", d, PER + 1 + (i % 3));
    end
  endtask

  initial begin
    test_reset;
    test_a5;
    test_parity;
    test_back_to_back;
    test_ignore;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
